// File: rtl/mixed_radix_time_counter.sv
// mixed_radix_time_counter: cascaded N-digit up/down time counter with a
// per-digit radix, built-in tick prescaler, load/clear and terminal-count stop.
// Optional lap register is compiled in with `define LAP_CAPTURE_EN.
// A base field of 0 in DIGIT_BASES stands for 2**NUMBER_OF_BITS_PER_DIGIT.

// One digit of the chain: ripple conditions, next values and load saturation.
module mrtc_digit #(
  parameter int         W    = 4,
  parameter logic [W-1:0] BASE = 4'd10
) (
  input  logic [W-1:0] cur,
  input  logic         lo_max,
  input  logic         lo_zero,
  input  logic [W-1:0] ld_raw,
  output logic         hi_max,
  output logic         hi_zero,
  output logic [W-1:0] up_nxt,
  output logic [W-1:0] dn_nxt,
  output logic [W-1:0] ld_sat
);
  // BASE==0 wraps to all-ones here, which is exactly the max of a 2**W digit
  localparam logic [W-1:0] MAXV = BASE - W'(1);

  logic at_max, at_zero;
  assign at_max  = (cur == MAXV);
  assign at_zero = (cur == '0);
  assign hi_max  = lo_max & at_max;
  assign hi_zero = lo_zero & at_zero;
  assign up_nxt  = !lo_max  ? cur : (at_max  ? '0   : cur + W'(1));
  assign dn_nxt  = !lo_zero ? cur : (at_zero ? MAXV : cur - W'(1));
  assign ld_sat  = (BASE != '0 && ld_raw >= BASE) ? MAXV : ld_raw;
endmodule

module mixed_radix_time_counter #(
  parameter int NUMBER_OF_DIGITS         = 4,
  parameter int NUMBER_OF_BITS_PER_DIGIT = 4,
  parameter logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] DIGIT_BASES = {4'd6, 4'd10, 4'd6, 4'd10},
  parameter int TICK_DIVIDER             = 100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic up_down,
  input  logic stop_at_zero,
  input  logic clear,
  input  logic load,
  input  logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] load_value,
  output logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] count,
  output logic tick,
  output logic carry_out,
  output logic zero,
  output logic done
`ifdef LAP_CAPTURE_EN
  ,
  input  logic lap,
  output logic [NUMBER_OF_DIGITS*NUMBER_OF_BITS_PER_DIGIT-1:0] lap_value,
  output logic lap_valid
`endif
);
  localparam int ND  = NUMBER_OF_DIGITS;
  localparam int NBD = NUMBER_OF_BITS_PER_DIGIT;
  localparam int NB  = ND * NBD;
  localparam int PW  = (TICK_DIVIDER > 1) ? $clog2(TICK_DIVIDER) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIVIDER - 1);

  logic [PW-1:0] presc;
  logic          step;
  logic [ND-1:0][NBD-1:0] cnt_q, up_nxt, dn_nxt, ld_sat;
  logic [ND:0]   lo_max, lo_zero;
  logic [NB-1:0] nxt;
  logic          nxt_carry, nxt_done, nxt_tick;

  assign count = cnt_q;
  assign step  = enable && (presc == PMAX);

  assign lo_max[0]  = 1'b1;
  assign lo_zero[0] = 1'b1;

  for (genvar g = 0; g < ND; g++) begin : g_dig
    mrtc_digit #(.W(NBD), .BASE(DIGIT_BASES[g*NBD +: NBD])) u_dig (
      .cur    (cnt_q[g]),
      .lo_max (lo_max[g]),
      .lo_zero(lo_zero[g]),
      .ld_raw (load_value[g*NBD +: NBD]),
      .hi_max (lo_max[g+1]),
      .hi_zero(lo_zero[g+1]),
      .up_nxt (up_nxt[g]),
      .dn_nxt (dn_nxt[g]),
      .ld_sat (ld_sat[g])
    );
  end

  // Prescaler: free-runs while enabled, restarts its phase on clear/load
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)               presc <= '0;
    else if (clear || load) presc <= '0;
    else if (enable)        presc <= step ? '0 : presc + PW'(1);
  end

  // Next count/flags: clear > load > step; halting at zero only sets done
  always_comb begin
    nxt       = cnt_q;
    nxt_carry = 1'b0;
    nxt_done  = done;
    nxt_tick  = 1'b0;
    if (clear) begin
      nxt      = '0;
      nxt_done = 1'b0;
    end else if (load) begin
      nxt      = ld_sat;
      nxt_done = 1'b0;
    end else if (step) begin
      nxt_tick = 1'b1;
      if (up_down) begin
        nxt       = up_nxt;
        nxt_carry = lo_max[ND];
      end else if (lo_zero[ND] && stop_at_zero) begin
        nxt_done  = 1'b1;
      end else begin
        nxt       = dn_nxt;
        nxt_carry = lo_zero[ND];
      end
    end
  end

  // Output registers; zero is derived from the value being stored
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      tick      <= 1'b0;
      carry_out <= 1'b0;
      zero      <= 1'b1;
      done      <= 1'b0;
    end else begin
      cnt_q     <= nxt;
      tick      <= nxt_tick;
      carry_out <= nxt_carry;
      zero      <= (nxt == '0);
      done      <= nxt_done;
    end
  end

`ifdef LAP_CAPTURE_EN
  // Lap snapshot of the displayed count; clear wins over a capture
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lap_value <= '0;
      lap_valid <= 1'b0;
    end else if (clear) begin
      lap_value <= '0;
      lap_valid <= 1'b0;
    end else if (lap) begin
      lap_value <= cnt_q;
      lap_valid <= 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_mixed_radix_time_counter.sv
// Scoreboard bench for mixed_radix_time_counter (TICK_DIVIDER=4, MM:SS bases).
// Stimulus pushes the expected post-step state per count step; a monitor pops
// and compares whenever the DUT pulses tick.
module tb_mixed_radix_time_counter;
  logic clk = 1'b0;
  logic rst, enable, up_down, stop_at_zero, clear, load;
  logic [15:0] load_value, count;
  logic tick, carry_out, zero, done;
`ifdef LAP_CAPTURE_EN
  logic lap, lap_valid;
  logic [15:0] lap_value;
`endif

  typedef struct packed {
    logic [15:0] cnt;
    logic        carry;
    logic        zero;
    logic        done;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;
  int   ticks = 0;

  always #5 clk = ~clk;

  mixed_radix_time_counter #(.TICK_DIVIDER(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .up_down(up_down),
    .stop_at_zero(stop_at_zero), .clear(clear), .load(load),
    .load_value(load_value), .count(count), .tick(tick),
    .carry_out(carry_out), .zero(zero), .done(done)
`ifdef LAP_CAPTURE_EN
    , .lap(lap), .lap_value(lap_value), .lap_valid(lap_valid)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  function automatic void push(input logic [15:0] c, input logic ca, input logic z, input logic d);
    exp_t e;
    e.cnt = c; e.carry = ca; e.zero = z; e.done = d;
    q.push_back(e);
  endfunction

  // Monitor: every tick pulse must match the next queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && tick === 1'b1) begin
        ticks++;
        if (q.size() == 0) begin
          total++;
          $display("FAIL unexpected_tick: got count=%h with empty expectation queue", count);
        end else begin
          e = q.pop_front();
          chk("step_state{cnt,carry,zero,done}", {13'd0, count, carry_out, zero, done},
              {13'd0, e.cnt, e.carry, e.zero, e.done});
        end
      end
    end
  end

  // Sync point a little after the falling edge, after the monitor has run
  task automatic nclk();
    @(negedge clk);
    #1;
  endtask

  task automatic step(input int n);
    enable = 1'b1;
    repeat (4 * n) nclk();
    enable = 1'b0;
  endtask

  task automatic ld(input logic [15:0] v);
    load_value = v;
    load = 1'b1;
    nclk();
    load = 1'b0;
  endtask

  initial begin
    int t0;
    rst = 1'b0; enable = 1'b0; up_down = 1'b1; stop_at_zero = 1'b0;
    clear = 1'b0; load = 1'b0; load_value = '0;
`ifdef LAP_CAPTURE_EN
    lap = 1'b0;
`endif
    repeat (3) nclk();
    chk("reset_count", 32'(count), 32'h0);
    chk("reset_zero", 32'(zero), 32'h1);
    chk("reset_tick", 32'(tick), 32'h0);
    chk("reset_carry", 32'(carry_out), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    rst = 1'b1;
    nclk();

    // Run up 40 clk: 10 steps, BCD-style 0001..0010
    for (int i = 1; i <= 9; i++) push(16'(i), 1'b0, 1'b0, 1'b0);
    push(16'h0010, 1'b0, 1'b0, 1'b0);
    t0 = ticks;
    step(10);
    chk("run_up_count", 32'(count), 32'h0010);
    chk("run_up_ticks", 32'(ticks - t0), 32'd10);
    chk("run_up_zero", 32'(zero), 32'h0);

    // Cascade wrap from 59:59
    ld(16'h5959);
    chk("load_5959", 32'(count), 32'h5959);
    push(16'h0000, 1'b1, 1'b1, 1'b0);
    step(1);
    nclk();
    chk("carry_one_cycle", 32'(carry_out), 32'h0);
    chk("tick_one_cycle", 32'(tick), 32'h0);

    // Countdown with halt at zero
    up_down = 1'b0; stop_at_zero = 1'b1;
    ld(16'h0002);
    chk("load_0002", 32'(count), 32'h0002);
    push(16'h0001, 1'b0, 1'b0, 1'b0);
    push(16'h0000, 1'b0, 1'b1, 1'b0);
    push(16'h0000, 1'b0, 1'b1, 1'b1);
    push(16'h0000, 1'b0, 1'b1, 1'b1);
    push(16'h0000, 1'b0, 1'b1, 1'b1);
    step(5);
    chk("halt_count", 32'(count), 32'h0);
    chk("halt_done", 32'(done), 32'h1);

    // clear+load in the same cycle as a step: clear wins, step discarded
    up_down = 1'b1;
    enable = 1'b1;
    repeat (3) nclk();
    clear = 1'b1; load = 1'b1; load_value = 16'h1234;
    nclk();
    clear = 1'b0; load = 1'b0; enable = 1'b0;
    chk("clr_count", 32'(count), 32'h0);
    chk("clr_done", 32'(done), 32'h0);
    chk("clr_tick", 32'(tick), 32'h0);
    chk("clr_zero", 32'(zero), 32'h1);
    // prescaler restarted: the next step needs a full 4 enabled cycles
    push(16'h0001, 1'b0, 1'b0, 1'b0);
    t0 = ticks;
    enable = 1'b1;
    repeat (3) nclk();
    chk("presc_cleared_no_early_tick", 32'(ticks - t0), 32'd0);
    nclk();
    enable = 1'b0;
    chk("presc_cleared_tick", 32'(ticks - t0), 32'd1);

    // Countdown wrap without stop
    up_down = 1'b0; stop_at_zero = 1'b0;
    ld(16'h0002);
    chk("load_clears_state", 32'(done), 32'h0);
    push(16'h0001, 1'b0, 1'b0, 1'b0);
    push(16'h0000, 1'b0, 1'b1, 1'b0);
    push(16'h5959, 1'b1, 1'b0, 1'b0);
    step(3);
    chk("down_wrap_count", 32'(count), 32'h5959);

    // load beats a coincident step
    enable = 1'b1;
    repeat (3) nclk();
    load = 1'b1; load_value = 16'h0105;
    nclk();
    load = 1'b0; enable = 1'b0;
    chk("load_over_step_count", 32'(count), 32'h0105);
    chk("load_over_step_tick", 32'(tick), 32'h0);

    // Saturating load
    ld(16'hFFFF);
    chk("sat_ffff", 32'(count), 32'h5959);
    ld(16'hC3C3);
    chk("sat_c3c3", 32'(count), 32'h5353);

`ifdef LAP_CAPTURE_EN
    ld(16'h0105);
    lap = 1'b1;
    nclk();
    lap = 1'b0;
    chk("lap_value", 32'(lap_value), 32'h0105);
    chk("lap_valid", 32'(lap_valid), 32'h1);
    up_down = 1'b1;
    push(16'h0106, 1'b0, 1'b0, 1'b0);
    step(1);
    chk("lap_hold", 32'(lap_value), 32'h0105);
    chk("lap_count_runs", 32'(count), 32'h0106);
`endif

    // Async reset while tick is high and count nonzero
    up_down = 1'b1;
    ld(16'h1234);
    push(16'h1235, 1'b0, 1'b0, 1'b0);
    enable = 1'b1;
    repeat (4) nclk();
    chk("pre_reset_tick", 32'(tick), 32'h1);
    rst = 1'b0;
    #1;
    chk("areset_count", 32'(count), 32'h0);
    chk("areset_zero", 32'(zero), 32'h1);
    chk("areset_tick", 32'(tick), 32'h0);
    chk("areset_carry", 32'(carry_out), 32'h0);
    chk("areset_done", 32'(done), 32'h0);
`ifdef LAP_CAPTURE_EN
    chk("areset_lap_valid", 32'(lap_valid), 32'h0);
`endif
    enable = 1'b0;
    nclk();
    rst = 1'b1;
    nclk();

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
